mdu_unit: RTL

//  Multi-cycle multiply/divide unit for the P5 pipeline; sits beside the ALU in EX.

---
 rtl/mdu_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit producing HI/LO after a fixed latency; mthi/mtlo in one cycle.
// Optional divide-by-zero flag output dz is enabled by defining MDU_DIVZERO_FLAG_EN.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDU_sel,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
`ifdef MDU_DIVZERO_FLAG_EN
    output logic        dz,
`endif
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_tmp_hi;
    logic [31:0]      r_tmp_lo;
    logic             r_tmp_we;

    logic        w_idle;
    logic        w_accept_md;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_done;
    logic        w_is_div;
    logic        w_signed;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic [31:0] w_divisor;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept_md = start & w_idle & ~MDU_sel[2];
    assign w_mthi      = start & w_idle & (MDU_sel == 3'b100);
    assign w_mtlo      = start & w_idle & (MDU_sel == 3'b101);
    assign w_done      = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
    assign w_is_div    = MDU_sel[1];
    assign w_signed    = ~MDU_sel[0];

    // Low 64 bits of the product of sign/zero-extended operands give both mult and multu.
    assign w_a64  = w_signed ? {{32{in1[31]}}, in1} : {32'd0, in1};
    assign w_b64  = w_signed ? {{32{in2[31]}}, in2} : {32'd0, in2};
    assign w_prod = w_a64 * w_b64;

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign w_neg_a    = w_signed & in1[31];
    assign w_neg_b    = w_signed & in2[31];
    assign w_mag_a    = w_neg_a ? (32'd0 - in1) : in1;
    assign w_mag_b    = w_neg_b ? (32'd0 - in2) : in2;
    assign w_div_zero = (in2 == 32'd0);
    assign w_divisor  = w_div_zero ? 32'd1 : w_mag_b;
    assign w_uq       = w_mag_a / w_divisor;
    assign w_ur       = w_mag_a % w_divisor;
    assign w_q        = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r        = w_neg_a ? (32'd0 - w_ur) : w_ur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_tmp_we <= 1'b0;
        end else if (w_accept_md) begin
            r_state  <= ST_BUSY;
            r_cnt    <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_tmp_hi <= w_is_div ? w_r : w_prod[63:32];
            r_tmp_lo <= w_is_div ? w_q : w_prod[31:0];
            r_tmp_we <= ~(w_is_div & w_div_zero);
        end else if (r_state == ST_BUSY) begin
            if (w_done) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (r_tmp_we) begin
                r_hi <= r_tmp_hi;
                r_lo <= r_tmp_lo;
            end
        end else begin
            if (w_mthi) r_hi <= in1;
            if (w_mtlo) r_lo <= in1;
        end
    end

`ifdef MDU_DIVZERO_FLAG_EN
    logic r_tmp_dz;
    logic r_dz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmp_dz <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_accept_md || w_mthi || w_mtlo) begin
            r_tmp_dz <= w_accept_md & w_is_div & w_div_zero;
            r_dz     <= 1'b0;
        end else if (w_done) begin
            r_dz <= r_tmp_dz;
        end
    end

    assign dz = r_dz;
`endif

    assign busy = (r_state == ST_BUSY);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
